dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data memory controller with byte/halfword/word
// loads and stores, little-endian lanes and a fixed access latency.
//
// Each aligned access holds DM_stall high for exactly LATENCY cycles (the
// accepting IDLE cycle plus LATENCY-1 WAIT cycles). The result is then
// presented for one DONE cycle with DM_stall low.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   MEM_mem_cmd  in   4   access command (MEM_* encoding, see Cmd* below)
//   MEM_mem_addr in  32   byte address
//   MEM_mem_din  in  32   store data, right-aligned
//   DM_mem_dout  out 32   formatted load data, non-zero only in DONE of a load
//   DM_stall     out  1   requester must hold its request
//   DM_misalign  out  1   misaligned request rejected this cycle
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_addr,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic        DM_stall,
    output logic        DM_misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // Command encodings, matching the MEM_* values of sys_defs.vh.
    localparam logic [3:0] CmdNone = 4'h0;
    localparam logic [3:0] CmdLb   = 4'h1;
    localparam logic [3:0] CmdLh   = 4'h2;
    localparam logic [3:0] CmdLw   = 4'h3;
    localparam logic [3:0] CmdLbu  = 4'h4;
    localparam logic [3:0] CmdLhu  = 4'h5;
    localparam logic [3:0] CmdSb   = 4'h9;
    localparam logic [3:0] CmdSh   = 4'hA;
    localparam logic [3:0] CmdSw   = 4'hB;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    function automatic logic is_load(input logic [3:0] c);
        return (c == CmdLb) || (c == CmdLh) || (c == CmdLw) || (c == CmdLbu) || (c == CmdLhu);
    endfunction

    function automatic logic is_store(input logic [3:0] c);
        return (c == CmdSb) || (c == CmdSh) || (c == CmdSw);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] c, input logic [1:0] a);
        logic half, word;
        half = (c == CmdLh) || (c == CmdLhu) || (c == CmdSh);
        word = (c == CmdLw) || (c == CmdSw);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] data_q, data_d;

    logic          in_valid, in_mis, accept;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic [31:0]   ld_fmt;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // Address bits above the word index alias and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:AW+2];

    assign in_valid = is_load(MEM_mem_cmd) || is_store(MEM_mem_cmd);
    assign in_mis   = is_misaligned(MEM_mem_cmd, MEM_mem_addr[1:0]);
    assign accept   = (state_q == StIdle) && in_valid && !in_mis;

    // Next-state, latching and load capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        data_d  = data_q;
        rd_en   = 1'b0;
        rd_idx  = addr_q[AW+1:2];
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cmd_d  = MEM_mem_cmd;
                    addr_d = MEM_mem_addr;
                    din_d  = MEM_mem_din;
                    if (LATENCY == 1) begin
                        // No WAIT: read now, from the address being latched.
                        state_d = StDone;
                        cnt_d   = 4'd0;
                        rd_en   = is_load(MEM_mem_cmd);
                        rd_idx  = MEM_mem_addr[AW+1:2];
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    rd_en   = is_load(cmd_q);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (rd_en) begin
            data_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            cmd_q   <= CmdNone;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            data_q  <= data_d;
        end
    end

    // Store lane selection; the write lands at the edge closing DONE.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = din_q;
        wr_idx  = addr_q[AW+1:2];
        case (cmd_q)
            CmdSb: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{din_q[7:0]}};
            end
            CmdSh: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{din_q[15:0]}};
            end
            CmdSw: begin
                wr_be   = 4'b1111;
                wr_data = din_q;
            end
            default: begin
                wr_be = 4'b0000;
            end
        endcase
    end

    assign wr_en = (state_q == StDone) && is_store(cmd_q) && !rst;

    // Storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Load formatting from the captured word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = data_q[7:0];
            2'd1:    ld_byte = data_q[15:8];
            2'd2:    ld_byte = data_q[23:16];
            default: ld_byte = data_q[31:24];
        endcase
        ld_half = addr_q[1] ? data_q[31:16] : data_q[15:0];
        case (cmd_q)
            CmdLb:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            CmdLbu:  ld_fmt = {24'd0, ld_byte};
            CmdLh:   ld_fmt = {{16{ld_half[15]}}, ld_half};
            CmdLhu:  ld_fmt = {16'd0, ld_half};
            CmdLw:   ld_fmt = data_q;
            default: ld_fmt = 32'd0;
        endcase
    end

    // Outputs are forced low while rst is high, independent of the inputs.
    always_comb begin
        DM_stall    = 1'b0;
        DM_misalign = 1'b0;
        DM_mem_dout = 32'd0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    DM_misalign = in_valid && in_mis;
                    DM_stall    = in_valid && !in_mis;
                end
                StWait: begin
                    DM_stall = 1'b1;
                end
                StDone: begin
                    DM_mem_dout = ld_fmt;
                end
                default: begin
                    DM_stall = 1'b0;
                end
            endcase
        end
    end

endmodule
